wb_port_arbiter: RTL and testbench

- Shares the register file's single write port between the in-order writeback stage and a long-latency unit (multiply/divide) that returns results out of band.
- Sits between the writeback stage and the register file / hazard unit.
- Queues long-latency results in a small FIFO and drains them in cycles when writeback does not use the port.
- Enforces WAW ordering, reports pending destinations to the hazard unit, and requests a bubble when queued results starve.

---
 rtl/wb_port_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-port arbiter: in-order writeback owns the register-file port, long-latency
// results wait in a small FIFO and drain in idle slots, with WAW kill and starvation stall.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [4:0]      rdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            lu_valid,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    output logic            RegWriteW2F,
    output logic [4:0]      rdW2F,
    output logic [XLEN-1:0] ResultW2F,
    output logic [31:0]     busy_mask,
    output logic            stall_req
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       rdMem   [DEPTH];
    logic [XLEN-1:0]  dataMem [DEPTH];
    logic [DEPTH-1:0] validMem;
    logic [DEPTH-1:0] killMem;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starveCnt;
    logic             stallReg;

    logic pipeWr;
    logic full;
    logic empty;
    logic headLive;
    logic livePop;
    logic killPop;
    logic doPop;
    logic doPush;

    assign pipeWr   = RegWriteW & (rdW != 5'd0);
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign headLive = ~empty & ~killMem[rdPtr];
    assign livePop  = headLive & ~pipeWr;
    assign killPop  = ~empty & killMem[rdPtr];
    assign doPop    = livePop | killPop;
    assign lu_ready = ~full & ~reset;
    // x0 results complete the handshake but have nowhere to go
    assign doPush   = lu_valid & lu_ready & (lu_rd != 5'd0);
    assign stall_req = stallReg;

    always_comb begin
        RegWriteW2F = 1'b0;
        rdW2F       = 5'd0;
        ResultW2F   = '0;
        if (!reset) begin
            if (pipeWr) begin
                RegWriteW2F = 1'b1;
                rdW2F       = rdW;
                ResultW2F   = ResultW;
            end else if (headLive) begin
                RegWriteW2F = 1'b1;
                rdW2F       = rdMem[rdPtr];
                ResultW2F   = dataMem[rdPtr];
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (validMem[i] && !killMem[i]) begin
                    busy_mask[rdMem[i]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            rdMem[wrPtr]   <= lu_rd;
            dataMem[wrPtr] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            validMem  <= '0;
            killMem   <= '0;
            starveCnt <= '0;
            stallReg  <= 1'b0;
        end else begin
            // A writeback is always younger than anything queued, so older same-rd entries die
            for (int i = 0; i < DEPTH; i++) begin
                if (pipeWr && validMem[i] && (rdMem[i] == rdW)) begin
                    killMem[i] <= 1'b1;
                end
            end
            if (doPop) begin
                validMem[rdPtr] <= 1'b0;
                rdPtr           <= rdPtr + PW'(1);
            end
            if (doPush) begin
                validMem[wrPtr] <= 1'b1;
                killMem[wrPtr]  <= pipeWr && (lu_rd == rdW);
                wrPtr           <= wrPtr + PW'(1);
            end
            count <= count + CW'(doPush) - CW'(doPop);

            if (doPop || empty) begin
                starveCnt <= '0;
            end else if (headLive && (starveCnt != SW'(STARVE_LIMIT))) begin
                starveCnt <= starveCnt + SW'(1);
            end

            // Empty also releases the stall so a fully killed queue cannot hold it forever
            if (livePop || empty) begin
                stallReg <= 1'b0;
            end else if (starveCnt == SW'(STARVE_LIMIT)) begin
                stallReg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: arbitration, WAW kill, starvation stall,
// full-FIFO backpressure, x0 handling and reset flush.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        RegWriteW;
    logic [4:0]  rdW;
    logic [31:0] ResultW;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        RegWriteW2F;
    logic [4:0]  rdW2F;
    logic [31:0] ResultW2F;
    logic [31:0] busy_mask;
    logic        stall_req;

    int passCnt  = 0;
    int totalCnt = 0;

    wb_port_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .RegWriteW(RegWriteW), .rdW(rdW), .ResultW(ResultW),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .RegWriteW2F(RegWriteW2F), .rdW2F(rdW2F), .ResultW2F(ResultW2F),
        .busy_mask(busy_mask), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idleInputs();
        RegWriteW = 1'b0; rdW = 5'd0; ResultW = '0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = '0;
    endtask

    // Inputs change just after the rising edge; checks happen on the falling edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idleInputs();
        nextCycle();
        @(negedge clk);
        totalCnt++; if (lu_ready !== 1'b0) $display("[TB] FAIL reset_lu_ready: got %b want 0", lu_ready); else passCnt++;
        totalCnt++; if (RegWriteW2F !== 1'b0) $display("[TB] FAIL reset_we: got %b want 0", RegWriteW2F); else passCnt++;
        totalCnt++; if (busy_mask !== 32'h0) $display("[TB] FAIL reset_busy: got %h want 0", busy_mask); else passCnt++;
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        totalCnt++; if (lu_ready !== 1'b1) $display("[TB] FAIL idle_lu_ready: got %b want 1", lu_ready); else passCnt++;
        totalCnt++; if ({RegWriteW2F, rdW2F, ResultW2F} !== 38'h0) $display("[TB] FAIL idle_port: got %b/%0d/%h want 0/0/0", RegWriteW2F, rdW2F, ResultW2F); else passCnt++;
        totalCnt++; if (busy_mask !== 32'h0) $display("[TB] FAIL idle_busy: got %h want 0", busy_mask); else passCnt++;
        totalCnt++; if (stall_req !== 1'b0) $display("[TB] FAIL idle_stall: got %b want 0", stall_req); else passCnt++;
    endtask

    task automatic test_single_push();
        nextCycle();
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEADBEEF;
        @(negedge clk);
        totalCnt++; if (RegWriteW2F !== 1'b0) $display("[TB] FAIL push_no_bypass: got %b want 0", RegWriteW2F); else passCnt++;
        nextCycle();
        idleInputs();
        @(negedge clk);
        totalCnt++; if ({RegWriteW2F, rdW2F, ResultW2F} !== {1'b1, 5'd5, 32'hDEADBEEF}) $display("[TB] FAIL push_drain: got %b/%0d/%h want 1/5/deadbeef", RegWriteW2F, rdW2F, ResultW2F); else passCnt++;
        totalCnt++; if (busy_mask !== 32'h0000_0020) $display("[TB] FAIL push_busy: got %h want 00000020", busy_mask); else passCnt++;
        nextCycle();
        @(negedge clk);
        totalCnt++; if (busy_mask !== 32'h0) $display("[TB] FAIL push_busy_clear: got %h want 0", busy_mask); else passCnt++;
        totalCnt++; if (RegWriteW2F !== 1'b0) $display("[TB] FAIL push_single_write: got %b want 0", RegWriteW2F); else passCnt++;
    endtask

    task automatic test_starvation();
        nextCycle();
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h77;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            lu_valid = 1'b0;
            RegWriteW = 1'b1; rdW = 5'd9; ResultW = 32'h99;
            @(negedge clk);
            totalCnt++; if ({RegWriteW2F, rdW2F, ResultW2F} !== {1'b1, 5'd9, 32'h99}) $display("[TB] FAIL starve_pipe_prio%0d: got %b/%0d/%h want 1/9/99", k, RegWriteW2F, rdW2F, ResultW2F); else passCnt++;
            totalCnt++; if (stall_req !== 1'b0) $display("[TB] FAIL starve_early%0d: got %b want 0", k, stall_req); else passCnt++;
            totalCnt++; if (busy_mask !== 32'h0000_0080) $display("[TB] FAIL starve_busy%0d: got %h want 00000080", k, busy_mask); else passCnt++;
        end
        nextCycle();
        idleInputs();
        @(negedge clk);
        totalCnt++; if (stall_req !== 1'b1) $display("[TB] FAIL starve_stall_rise: got %b want 1", stall_req); else passCnt++;
        totalCnt++; if ({RegWriteW2F, rdW2F, ResultW2F} !== {1'b1, 5'd7, 32'h77}) $display("[TB] FAIL starve_drain: got %b/%0d/%h want 1/7/77", RegWriteW2F, rdW2F, ResultW2F); else passCnt++;
        nextCycle();
        @(negedge clk);
        totalCnt++; if (stall_req !== 1'b0) $display("[TB] FAIL starve_stall_fall: got %b want 0", stall_req); else passCnt++;
        totalCnt++; if (RegWriteW2F !== 1'b0) $display("[TB] FAIL starve_after: got %b want 0", RegWriteW2F); else passCnt++;
    endtask

    task automatic test_waw_kill();
        nextCycle();
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h11;
        nextCycle();
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h33;
        RegWriteW = 1'b1; rdW = 5'd3; ResultW = 32'h22;
        @(negedge clk);
        totalCnt++; if ({RegWriteW2F, rdW2F, ResultW2F} !== {1'b1, 5'd3, 32'h22}) $display("[TB] FAIL waw_pipe: got %b/%0d/%h want 1/3/22", RegWriteW2F, rdW2F, ResultW2F); else passCnt++;
        totalCnt++; if (busy_mask !== 32'h0000_0008) $display("[TB] FAIL waw_busy_before: got %h want 00000008", busy_mask); else passCnt++;
        nextCycle();
        idleInputs();
        @(negedge clk);
        totalCnt++; if (busy_mask !== 32'h0) $display("[TB] FAIL waw_busy_after: got %h want 0", busy_mask); else passCnt++;
        for (int k = 0; k < 4; k++) begin
            totalCnt++; if (RegWriteW2F !== 1'b0) $display("[TB] FAIL waw_stale_write%0d: got %b rd %0d data %h want no write", k, RegWriteW2F, rdW2F, ResultW2F); else passCnt++;
            nextCycle();
            @(negedge clk);
        end
        totalCnt++; if (lu_ready !== 1'b1) $display("[TB] FAIL waw_drained: got %b want 1", lu_ready); else passCnt++;
    endtask

    task automatic test_fill();
        RegWriteW = 1'b1; rdW = 5'd20; ResultW = 32'hAAAA;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            lu_valid = 1'b1; lu_rd = 5'(12 + k); lu_data = 32'h100 + 32'(k);
            @(negedge clk);
            totalCnt++; if (lu_ready !== 1'b1) $display("[TB] FAIL fill_ready%0d: got %b want 1", k, lu_ready); else passCnt++;
        end
        nextCycle();
        lu_valid = 1'b1; lu_rd = 5'd30; lu_data = 32'h999;
        @(negedge clk);
        totalCnt++; if (lu_ready !== 1'b0) $display("[TB] FAIL fill_full: got %b want 0", lu_ready); else passCnt++;
        totalCnt++; if (busy_mask !== 32'h0000_F000) $display("[TB] FAIL fill_busy: got %h want 0000f000", busy_mask); else passCnt++;
        nextCycle();
        idleInputs();
        @(negedge clk);
        totalCnt++; if (lu_ready !== 1'b0) $display("[TB] FAIL fill_ready_first_pop: got %b want 0", lu_ready); else passCnt++;
        for (int k = 0; k < 4; k++) begin
            totalCnt++; if ({RegWriteW2F, rdW2F, ResultW2F} !== {1'b1, 5'(12 + k), 32'h100 + 32'(k)}) $display("[TB] FAIL fill_order%0d: got %b/%0d/%h want 1/%0d/%h", k, RegWriteW2F, rdW2F, ResultW2F, 12 + k, 32'h100 + 32'(k)); else passCnt++;
            nextCycle();
            @(negedge clk);
            if (k == 0) begin
                totalCnt++; if (lu_ready !== 1'b1) $display("[TB] FAIL fill_ready_return: got %b want 1", lu_ready); else passCnt++;
            end
        end
        totalCnt++; if ({RegWriteW2F, busy_mask} !== 33'h0) $display("[TB] FAIL fill_empty: got we %b busy %h want 0/0", RegWriteW2F, busy_mask); else passCnt++;
    endtask

    task automatic test_x0();
        nextCycle();
        lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h44;
        nextCycle();
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h55;
        RegWriteW = 1'b1; rdW = 5'd0; ResultW = 32'h66;
        @(negedge clk);
        totalCnt++; if ({RegWriteW2F, rdW2F, ResultW2F} !== {1'b1, 5'd4, 32'h44}) $display("[TB] FAIL x0_head_takes_port: got %b/%0d/%h want 1/4/44", RegWriteW2F, rdW2F, ResultW2F); else passCnt++;
        totalCnt++; if (busy_mask !== 32'h0000_0010) $display("[TB] FAIL x0_busy_head: got %h want 00000010", busy_mask); else passCnt++;
        nextCycle();
        idleInputs();
        @(negedge clk);
        totalCnt++; if (busy_mask !== 32'h0) $display("[TB] FAIL x0_not_enqueued: got %h want 0", busy_mask); else passCnt++;
        totalCnt++; if (RegWriteW2F !== 1'b0) $display("[TB] FAIL x0_no_write: got %b rd %0d want 0", RegWriteW2F, rdW2F); else passCnt++;
    endtask

    task automatic test_reset_midstream();
        RegWriteW = 1'b1; rdW = 5'd20; ResultW = 32'hBBBB;
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            lu_valid = 1'b1; lu_rd = 5'(10 + k); lu_data = 32'h200 + 32'(k);
        end
        nextCycle();
        lu_valid = 1'b0;
        @(negedge clk);
        totalCnt++; if (busy_mask !== 32'h0000_1C00) $display("[TB] FAIL mid_busy_queued: got %h want 00001c00", busy_mask); else passCnt++;
        nextCycle();
        idleInputs();
        reset = 1'b1;
        @(negedge clk);
        totalCnt++; if ({lu_ready, RegWriteW2F, busy_mask} !== 34'h0) $display("[TB] FAIL mid_in_reset: got rdy %b we %b busy %h want 0/0/0", lu_ready, RegWriteW2F, busy_mask); else passCnt++;
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        totalCnt++; if (busy_mask !== 32'h0) $display("[TB] FAIL mid_busy_flushed: got %h want 0", busy_mask); else passCnt++;
        totalCnt++; if (stall_req !== 1'b0) $display("[TB] FAIL mid_stall_flushed: got %b want 0", stall_req); else passCnt++;
        for (int k = 0; k < 4; k++) begin
            totalCnt++; if (RegWriteW2F !== 1'b0) $display("[TB] FAIL mid_ghost_write%0d: got %b rd %0d want no write", k, RegWriteW2F, rdW2F); else passCnt++;
            nextCycle();
            @(negedge clk);
        end
    endtask

    initial begin
        idleInputs();
        reset = 1'b1;
        test_reset();
        test_single_push();
        test_starvation();
        test_waw_kill();
        test_fill();
        test_x0();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
